// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_pkg
//  Description : Shared types and constants for the sequential signed
//                multiply/divide unit (multdiv_seq and its sub-modules).
//                  - state_t : controller states
//                  - op_t    : operation selected on a start pulse
//  Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

    localparam int MULTDIV_WIDTH = 32;
    // One shift/add or shift/subtract step per operand bit.
    localparam int MULTDIV_ITERS = MULTDIV_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

endpackage : multdiv_pkg
`default_nettype wire

// File: rtl/multdiv_counter.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_counter
//  Description : Iteration counter for multdiv_seq. Synchronous clear
//                (reset or start), counts while enabled, flags the last
//                iteration (count == WIDTH-1).
//  Ports       : clk   - clock
//                rst   - synchronous active-high reset
//                i_clr - synchronous clear (new operation starting)
//                i_en  - advance one iteration
//                o_tc  - terminal count: current iteration is the last
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_counter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MULTDIV_ITERS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int c_CNT_W = $clog2(WIDTH) + 1;

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == c_CNT_W'(WIDTH - 1));

endmodule : multdiv_counter
`default_nettype wire

// File: rtl/multdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_seq
//  Description : Sequential signed multiply / divide unit. Magnitudes are
//                latched on a start pulse; one shift-and-add (MULT) or
//                restoring shift-subtract (DIV) step per cycle; the sign is
//                applied at the end. Result/exception are registered and
//                qualified by a one-cycle data_resultRDY pulse.
//  Ports       : clock, reset (sync, active-high)
//                data_operandA/B   - signed operands, sampled on start only
//                ctrl_MULT/ctrl_DIV- start pulses (MULT wins if both)
//                data_result       - product low half or quotient
//                data_exception    - overflow / divide-by-zero
//                data_resultRDY    - one-cycle result-valid pulse
//                busy              - operation in flight (up to RDY cycle)
//  Config      : MULTDIV_EARLY_TERM_EN - when defined, MULT finishes as
//                soon as the remaining multiplier magnitude is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MULTDIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t             r_state;
    logic               r_sign;
    logic [WIDTH-1:0]   r_a;       // dividend magnitude, shifted out MSB-first
    logic [WIDTH:0]     r_b;       // multiplier (shifted right) / divisor
    logic [2*WIDTH-1:0] r_mcand;   // multiplicand, shifted left each step
    logic [2*WIDTH-1:0] r_acc;     // product, or {remainder, quotient}
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;
    logic               r_rdy;
    logic               r_busy;

    // ---------------- start / operand magnitudes ----------------
    logic             w_start;
    op_t              w_op;
    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH:0]   w_abs_a;
    logic [WIDTH:0]   w_abs_b;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_op    = ctrl_MULT ? OP_MUL : OP_DIV;

    // One extra bit so |MIN_INT| is representable without wrapping.
    assign w_a_ext = {data_operandA[WIDTH-1], data_operandA};
    assign w_b_ext = {data_operandB[WIDTH-1], data_operandB};
    assign w_abs_a = data_operandA[WIDTH-1] ? -w_a_ext : w_a_ext;
    assign w_abs_b = data_operandB[WIDTH-1] ? -w_b_ext : w_b_ext;

    // ---------------- iteration counter ----------------
    logic w_run;
    logic w_tc;

    assign w_run = (r_state == MUL_RUN) || (r_state == DIV_RUN);

    multdiv_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clock),
        .rst   (reset),
        .i_clr (w_start),
        .i_en  (w_run),
        .o_tc  (w_tc)
    );

    // ---------------- multiply step ----------------
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH:0]     w_prod_hi;
    logic               w_mul_ovf;
    logic               w_mul_last;

    assign w_mul_acc = r_acc + (r_b[0] ? r_mcand : '0);
    assign w_prod_s  = r_sign ? -w_mul_acc : w_mul_acc;
    // Overflow when the upper half is not a pure sign extension of bit WIDTH-1.
    assign w_prod_hi = w_prod_s[2*WIDTH-1:WIDTH-1];
    assign w_mul_ovf = ~((&w_prod_hi) | ~(|w_prod_hi));

`ifdef MULTDIV_EARLY_TERM_EN
    // Stop once no multiplier bits remain above the one consumed this cycle.
    assign w_mul_last = w_tc | (r_b[WIDTH:1] == '0);
`else
    assign w_mul_last = w_tc;
`endif

    // ---------------- divide step (restoring) ----------------
    logic [WIDTH-1:0] w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_nx;
    logic [2*WIDTH-1:0] w_div_acc;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_quot_s;
    logic             w_div_zero;

    // Remainder always stays below the divisor, so WIDTH bits hold the shift.
    assign w_rem_sh  = {r_acc[2*WIDTH-2:WIDTH], r_a[WIDTH-1]};
    assign w_diff    = {1'b0, w_rem_sh} - r_b;
    assign w_qbit    = ~w_diff[WIDTH];
    assign w_rem_nx  = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh;
    assign w_div_acc = {w_rem_nx, r_acc[WIDTH-2:0], w_qbit};
    assign w_quot    = w_div_acc[WIDTH-1:0];
    assign w_quot_s  = r_sign ? -w_quot : w_quot;
    assign w_div_zero = (r_b == '0);

    // ---------------- controller / datapath registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_sign   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else if (w_start) begin
            // A start in any state aborts whatever was running.
            r_state  <= (w_op == OP_MUL) ? MUL_RUN : DIV_RUN;
            r_sign   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_a      <= w_abs_a[WIDTH-1:0];
            r_b      <= w_abs_b;
            r_mcand  <= {{(WIDTH-1){1'b0}}, w_abs_a};
            r_acc    <= '0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            case (r_state)
                MUL_RUN: begin
                    r_acc   <= w_mul_acc;
                    r_mcand <= r_mcand << 1;
                    r_b     <= r_b >> 1;
                    if (w_mul_last) begin
                        r_state  <= DONE;
                        r_result <= w_prod_s[WIDTH-1:0];
                        r_exc    <= w_mul_ovf;
                        r_rdy    <= 1'b1;
                    end
                end
                DIV_RUN: begin
                    r_acc <= w_div_acc;
                    r_a   <= r_a << 1;
                    if (w_tc) begin
                        r_state <= DONE;
                        r_rdy   <= 1'b1;
                        if (w_div_zero) begin
                            r_result <= '0;
                            r_exc    <= 1'b1;
                        end else begin
                            r_result <= w_quot_s;
                            // Positive quotient with MSB set: MIN_INT / -1.
                            r_exc    <= ~r_sign & w_quot[WIDTH-1];
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_rdy   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_rdy   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule : multdiv_seq
`default_nettype wire
